// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx
// Description : PS/2 device-side transmitter with a 4-entry byte FIFO.
//               Emits 11-bit odd-parity frames on ps2_clk/ps2_data.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx #(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam logic [7:0] c_HALF_LAST = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] c_GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] c_LAST_BIT  = 4'd10;

    logic [1:0]  r_state;
    logic [3:0]  r_bit_idx;
    logic [7:0]  r_phase;
    logic [10:0] r_frame;
    logic        r_ps2_clk;
    logic        r_ps2_data;

    logic [7:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;
    logic [10:0] w_frame;
    logic [3:0]  w_next_idx;

    assign tx_ready   = (r_count != 3'd4);
    assign busy       = (r_state != c_ST_IDLE) || (r_count != 3'd0);
    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;

    // Pop only from IDLE, so a freshly pushed byte waits at least one edge.
    assign w_push     = tx_valid && tx_ready;
    assign w_pop      = (r_state == c_ST_IDLE) && (r_count != 3'd0) && !inhibit;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_frame    = {1'b1, ~^w_head, w_head, 1'b0};
    assign w_next_idx = r_bit_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_bit_idx  <= 4'd0;
            r_phase    <= 8'd0;
            r_frame    <= 11'h7FF;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_frame    <= w_frame;
                        r_bit_idx  <= 4'd0;
                        r_phase    <= 8'd0;
                        r_ps2_clk  <= 1'b1;
                        r_ps2_data <= 1'b0;
                        r_state    <= c_ST_HIGH;
                    end
                end
                c_ST_HIGH: begin
                    if (r_phase == c_HALF_LAST) begin
                        r_phase   <= 8'd0;
                        r_ps2_clk <= 1'b0;
                        r_state   <= c_ST_LOW;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                c_ST_LOW: begin
                    if (r_phase == c_HALF_LAST) begin
                        r_phase   <= 8'd0;
                        r_ps2_clk <= 1'b1;
                        // Data only moves on the rising edge of ps2_clk.
                        if (r_bit_idx < c_LAST_BIT) begin
                            r_bit_idx  <= w_next_idx;
                            r_ps2_data <= r_frame[w_next_idx];
                            r_state    <= c_ST_HIGH;
                        end else begin
                            r_ps2_data <= 1'b1;
                            r_state    <= c_ST_GAP;
                        end
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                c_ST_GAP: begin
                    if (r_phase == c_GAP_LAST) begin
                        r_phase <= 8'd0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_tx
// Description : Scoreboard bench for ps2_tx with a PS/2 receiver monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

    localparam int HP  = 4;
    localparam int GAP = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       inhibit  = 1'b0;
    logic       tx_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Expected frames: {parity, data}, parity worked out by hand per byte.
    logic [8:0] sb [$];

    ps2_tx #(
        .HALF_PERIOD(HP),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .inhibit (inhibit),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic par);
        int   waited;
        logic acc;
        waited   = 0;
        acc      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!acc && waited < 500) begin
            acc = tx_ready;
            tick();
            waited++;
        end
        tx_valid = 1'b0;
        if (acc) sb.push_back({par, d});
        else     check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(n < 5000), 1);
    endtask

    // Receiver monitor: samples ps2_data on each ps2_clk fall.
    initial begin
        int         nbits;
        int         idle_run;
        bit         have_prev;
        logic       prev_clk;
        logic       prev_data;
        logic [10:0] sh;
        logic [8:0] expv;
        nbits = 0; idle_run = 0; have_prev = 0;
        prev_clk = 1'b1; prev_data = 1'b1; sh = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits = 0; idle_run = 0; have_prev = 0;
                prev_clk = 1'b1; prev_data = 1'b1;
            end else begin
                if (!prev_clk && !ps2_clk)
                    check("data_stable_low", int'(ps2_data), int'(prev_data));
                if (ps2_clk && prev_clk && !ps2_data && prev_data && nbits == 0 && have_prev)
                    check("gap_len_ok", int'(idle_run >= GAP), 1);
                if (ps2_clk && ps2_data) idle_run++;
                else                     idle_run = 0;
                if (prev_clk && !ps2_clk) begin
                    sh[nbits] = ps2_data;
                    nbits++;
                    if (nbits == 11) begin
                        check("start_bit", int'(sh[0]), 0);
                        check("stop_bit", int'(sh[10]), 1);
                        check("odd_parity", int'(^sh[9:1]), 1);
                        if (sb.size() == 0) begin
                            check("unexpected_frame", 1, 0);
                        end else begin
                            expv = sb.pop_front();
                            check("rx_byte", int'(sh[8:1]), int'(expv[7:0]));
                            check("rx_parity", int'(sh[9]), int'(expv[8]));
                        end
                        nbits     = 0;
                        have_prev = 1;
                    end
                end
                prev_clk  = ps2_clk;
                prev_data = ps2_data;
            end
        end
    end

    initial begin
        int activity;

        // Reset state
        repeat (3) tick();
        check("rst_ps2_clk", int'(ps2_clk), 1);
        check("rst_ps2_data", int'(ps2_data), 1);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        check("post_rst_busy", int'(busy), 0);

        // Single byte 0x1C with exact edge timing
        tx_valid = 1'b1;
        tx_data  = 8'h1C;
        tick();                                      // edge 0: push
        tx_valid = 1'b0;
        sb.push_back({1'b0, 8'h1C});
        check("t1_e0_data_idle", int'(ps2_data), 1);
        check("t1_e0_busy", int'(busy), 1);
        tick();                                      // edge 1
        check("t1_e1_start_data", int'(ps2_data), 0);
        check("t1_e1_clk_high", int'(ps2_clk), 1);
        repeat (3) tick();                           // edge 4
        check("t1_e4_clk_high", int'(ps2_clk), 1);
        tick();                                      // edge 5
        check("t1_e5_clk_fall", int'(ps2_clk), 0);
        repeat (83) tick();                          // edge 88
        check("t1_e88_clk_low", int'(ps2_clk), 0);
        check("t1_e88_stop", int'(ps2_data), 1);
        tick();                                      // edge 89: GAP
        check("t1_e89_clk_high", int'(ps2_clk), 1);
        check("t1_e89_busy", int'(busy), 1);
        repeat (7) tick();                           // edge 96
        check("t1_e96_gap_busy", int'(busy), 1);
        tick();                                      // edge 97: IDLE
        check("t1_e97_idle", int'(busy), 0);

        // Parity cases
        push(8'hF0, 1'b1);
        push(8'h00, 1'b1);
        wait_idle();

        // Back-to-back: fill FIFO while inhibited, 5th waits for a pop
        inhibit = 1'b1;
        push(8'hE0, 1'b0);
        push(8'hF0, 1'b1);
        push(8'h1C, 1'b0);
        push(8'h5A, 1'b1);
        check("b2b_full_ready", int'(tx_ready), 0);
        inhibit = 1'b0;
        push(8'h29, 1'b0);
        wait_idle();

        // Inhibit holds a queued byte
        inhibit = 1'b1;
        push(8'h1C, 1'b0);
        activity = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!ps2_clk || !ps2_data) activity++;
        end
        check("inh_no_activity", activity, 0);
        check("inh_busy", int'(busy), 1);
        inhibit = 1'b0;
        tick();
        check("inh_release_start", int'(ps2_data), 0);
        repeat (30) tick();
        inhibit = 1'b1;                              // mid-frame: must complete
        wait_idle();
        inhibit = 1'b0;

        // Reset mid-frame with two bytes queued
        push(8'h1C, 1'b0);
        push(8'h5A, 1'b1);
        push(8'h29, 1'b0);
        repeat (40) tick();
        check("rstmid_in_frame", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_ps2_clk", int'(ps2_clk), 1);
        check("rstmid_ps2_data", int'(ps2_data), 1);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_tx_ready", int'(tx_ready), 1);
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        activity = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!ps2_clk || !ps2_data || busy) activity++;
        end
        check("rstmid_quiet_after", activity, 0);
        push(8'h1C, 1'b0);
        wait_idle();

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
